// File: rtl/karatsuba_divider_pkg.sv
// Shared definitions for the Karatsuba restoring divider.
//   state_t     : controller state encoding (IDLE / RUN / DONE)
//   cnt_width() : width of the step counter for an N-bit divisor; the counter
//                 counts 2N-1 down to 0
package karatsuba_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // clog2(2N), never narrower than one bit
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(2 * n);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/karatsuba_divider_if.sv
// Handshake/data bundle of the Karatsuba divider.
//   in_valid/in_ready     : operation request handshake
//   dividend (2N)         : unsigned numerator
//   divisor  (N)          : unsigned denominator
//   out_valid/out_ready   : result handshake
//   quotient (2N)         : dividend / divisor
//   remainder (N)         : dividend % divisor
//   div_by_zero           : held result came from divisor == 0
// master = requester/consumer, slave = divider.
interface karatsuba_divider_if #(
  parameter int N = 10
);

  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   dividend;
  logic [N-1:0]     divisor;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   quotient;
  logic [N-1:0]     remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/karatsuba_divider_div_step.sv
// One combinational restoring-division step.
//   rem_in  (N+1) : partial remainder
//   q_in    (2N)  : dividend/quotient shift register
//   divisor (N)   : denominator
//   rem_out (N+1) : next partial remainder
//   q_out   (2N)  : q_in shifted left with the new quotient bit in the LSB
module div_step #(
  parameter int N = 10
) (
  input  logic [N:0]     rem_in,
  input  logic [2*N-1:0] q_in,
  input  logic [N-1:0]   divisor,
  output logic [N:0]     rem_out,
  output logic [2*N-1:0] q_out
);

  logic [N:0] shifted_s;
  logic       ge_s;

  // Shift next dividend bit into the remainder, subtract when it fits.
  // rem_in[N] is zero in every legal sequence; treating a set bit as
  // "already larger than the divisor" keeps the step exact on the full
  // N+1-bit value instead of silently dropping that bit.
  always_comb begin
    shifted_s = {rem_in[N-1:0], q_in[2*N-1]};
    ge_s      = rem_in[N] | (shifted_s >= {1'b0, divisor});
    if (ge_s) begin
      rem_out = shifted_s - {1'b0, divisor};
    end else begin
      rem_out = shifted_s;
    end
    q_out = {q_in[2*N-2:0], ge_s};
  end

endmodule

// File: rtl/karatsuba_divider.sv
// Sequential restoring divider (inverse of the Karatsuba multiplier).
// A 2N-bit dividend is divided by an N-bit divisor, one quotient bit per
// clock. A nonzero divisor gives a result 2N cycles after acceptance; a zero
// divisor completes immediately with quotient all ones, remainder equal to
// dividend[N-1:0] and div_by_zero set.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, discards any in-flight operation
//   bus : karatsuba_divider_if slave port (handshakes, operands, results)
module karatsuba_divider
  import karatsuba_divider_pkg::*;
#(
  parameter int N = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  karatsuba_divider_if.slave   bus
);

  localparam int             CW       = cnt_width(N);
  localparam logic [CW-1:0]  CNT_LAST = CW'(2 * N - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_ZERO = CW'(0);

  state_t           state_r,     state_nx_s;
  logic [CW-1:0]    cnt_r,       cnt_nx_s;
  logic [N:0]       rem_r,       rem_nx_s;
  logic [2*N-1:0]   q_r,         q_nx_s;
  logic [N-1:0]     dvs_r,       dvs_nx_s;
  logic [2*N-1:0]   quotient_r,  quotient_nx_s;
  logic [N-1:0]     remainder_r, remainder_nx_s;
  logic             dbz_r,       dbz_nx_s;
  logic             in_ready_r,  in_ready_nx_s;
  logic             out_valid_r, out_valid_nx_s;

  logic [N:0]       step_rem_s;
  logic [2*N-1:0]   step_q_s;

  div_step #(.N(N)) u_step (
    .rem_in  (rem_r),
    .q_in    (q_r),
    .divisor (dvs_r),
    .rem_out (step_rem_s),
    .q_out   (step_q_s)
  );

  // Next-state and next-register values; everything holds unless changed.
  always_comb begin
    state_nx_s     = state_r;
    cnt_nx_s       = cnt_r;
    rem_nx_s       = rem_r;
    q_nx_s         = q_r;
    dvs_nx_s       = dvs_r;
    quotient_nx_s  = quotient_r;
    remainder_nx_s = remainder_r;
    dbz_nx_s       = dbz_r;

    case (state_r)
      IDLE: begin
        if (bus.in_valid && in_ready_r) begin
          dvs_nx_s = bus.divisor;
          if (bus.divisor != {N{1'b0}}) begin
            state_nx_s = RUN;
            cnt_nx_s   = CNT_LAST;
            rem_nx_s   = {(N+1){1'b0}};
            q_nx_s     = bus.dividend;
          end else begin
            state_nx_s     = DONE;
            quotient_nx_s  = {(2*N){1'b1}};
            remainder_nx_s = bus.dividend[N-1:0];
            dbz_nx_s       = 1'b1;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        rem_nx_s = step_rem_s;
        q_nx_s   = step_q_s;
        if (cnt_r == CNT_ZERO) begin
          state_nx_s     = DONE;
          quotient_nx_s  = step_q_s;
          remainder_nx_s = step_rem_s[N-1:0];
          dbz_nx_s       = 1'b0;
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase

    // Handshake flags are registered copies of the upcoming state
    in_ready_nx_s  = (state_nx_s == IDLE);
    out_valid_nx_s = (state_nx_s == DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      rem_r       <= {(N+1){1'b0}};
      q_r         <= {(2*N){1'b0}};
      dvs_r       <= {N{1'b0}};
      quotient_r  <= {(2*N){1'b0}};
      remainder_r <= {N{1'b0}};
      dbz_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      rem_r       <= rem_nx_s;
      q_r         <= q_nx_s;
      dvs_r       <= dvs_nx_s;
      quotient_r  <= quotient_nx_s;
      remainder_r <= remainder_nx_s;
      dbz_r       <= dbz_nx_s;
      in_ready_r  <= in_ready_nx_s;
      out_valid_r <= out_valid_nx_s;
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_karatsuba_divider.sv
// Self-checking bench for karatsuba_divider (N = 10): table of directed
// vectors, backpressure/busy and mid-run reset sequences, then random
// a*b+r operands checked against plain integer arithmetic.
module tb_karatsuba_divider;

  localparam int N = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  karatsuba_divider_if #(.N(N)) dif ();

  karatsuba_divider #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic [2*N-1:0] exp_q;
    logic [N-1:0]   exp_r;
    logic           exp_dbz;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Runs one operation; hold = cycles with out_ready low in DONE,
  // poke = drive in_valid with junk operands while busy.
  task automatic run_op(input logic [2*N-1:0] a, input logic [N-1:0] b,
                        input int hold, input bit poke,
                        output logic [2*N-1:0] q, output logic [N-1:0] r,
                        output logic dbz, output int lat);
    int guard;
    lat = -1;
    @(negedge clk);
    guard = 0;
    while (!dif.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_timeout", 64'(guard < 100), 64'd1);
    dif.dividend = a;
    dif.divisor  = b;
    dif.in_valid = 1'b1;
    dif.out_ready = 1'b0;
    @(posedge clk);
    #1;
    // Operands must be sampled only at the accept edge
    dif.dividend = 20'($urandom);
    dif.divisor  = 10'($urandom);
    dif.in_valid = poke;
    lat = 0;
    while (!dif.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (!dif.out_valid) begin
        chk("busy_in_ready", 64'(dif.in_ready), 64'd0);
      end
    end
    chk("out_valid_timeout", 64'(dif.out_valid), 64'd1);
    q   = dif.quotient;
    r   = dif.remainder;
    dbz = dif.div_by_zero;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold_valid",    64'(dif.out_valid),   64'd1);
      chk("hold_in_ready", 64'(dif.in_ready),    64'd0);
      chk("hold_q",        64'(dif.quotient),    64'(q));
      chk("hold_r",        64'(dif.remainder),   64'(r));
      chk("hold_dbz",      64'(dif.div_by_zero), 64'(dbz));
    end
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    dif.out_ready = 1'b0;
    chk("post_hs_valid",    64'(dif.out_valid), 64'd0);
    chk("post_hs_in_ready", 64'(dif.in_ready),  64'd1);
    chk("post_hs_q_kept",   64'(dif.quotient),  64'(q));
  endtask

  logic [2*N-1:0] q;
  logic [N-1:0]   r;
  logic           dbz;
  int             lat;
  int             a_i, b_i, r_i, seen;

  initial begin
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;

    vecs[0] = '{20'd1046529, 10'd1023, 20'd1023,    10'd0,  1'b0};
    vecs[1] = '{20'd1000,    10'd7,    20'd142,     10'd6,  1'b0};
    vecs[2] = '{20'd1048575, 10'd1,    20'd1048575, 10'd0,  1'b0};
    vecs[3] = '{20'd12345,   10'd0,    20'hFFFFF,   10'd57, 1'b1};
    vecs[4] = '{20'd1048575, 10'd1023, 20'd1025,    10'd0,  1'b0};
    vecs[5] = '{20'd5,       10'd10,   20'd0,       10'd5,  1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(dif.in_ready),    64'd1);
    chk("rst_out_valid", 64'(dif.out_valid),   64'd0);
    chk("rst_q",         64'(dif.quotient),    64'd0);
    chk("rst_r",         64'(dif.remainder),   64'd0);
    chk("rst_dbz",       64'(dif.div_by_zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].dividend, vecs[i].divisor, 0, 1'b0, q, r, dbz, lat);
      chk("vec_q",   64'(q),   64'(vecs[i].exp_q));
      chk("vec_r",   64'(r),   64'(vecs[i].exp_r));
      chk("vec_dbz", 64'(dbz), 64'(vecs[i].exp_dbz));
      chk("vec_lat", 64'(lat), vecs[i].exp_dbz ? 64'd0 : 64'(2 * N));
    end

    // Backpressure for 5 cycles with in_valid poked while busy
    run_op(20'd1000, 10'd7, 5, 1'b1, q, r, dbz, lat);
    chk("bp_q", 64'(q), 64'd142);
    chk("bp_r", 64'(r), 64'd6);
    run_op(20'd1046529, 10'd1023, 0, 1'b0, q, r, dbz, lat);
    chk("after_bp_q",   64'(q),   64'd1023);
    chk("after_bp_lat", 64'(lat), 64'(2 * N));

    // Reset during RUN
    @(negedge clk);
    dif.dividend = 20'd1046529;
    dif.divisor  = 10'd1023;
    dif.in_valid = 1'b1;
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_in_ready",  64'(dif.in_ready),    64'd1);
    chk("mid_rst_out_valid", 64'(dif.out_valid),   64'd0);
    chk("mid_rst_q",         64'(dif.quotient),    64'd0);
    chk("mid_rst_r",         64'(dif.remainder),   64'd0);
    chk("mid_rst_dbz",       64'(dif.div_by_zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (dif.out_valid) seen = 1;
    end
    chk("no_stale_result", 64'(seen), 64'd0);

    // Random a*b + r against integer arithmetic
    for (int k = 0; k < 200; k++) begin
      a_i = int'($urandom_range(1023, 0));
      b_i = int'($urandom_range(1023, 1));
      r_i = int'($urandom_range(b_i - 1, 0));
      run_op(20'(a_i * b_i + r_i), 10'(b_i), k % 3, 1'b0, q, r, dbz, lat);
      chk("rnd_q",   64'(q),   64'(a_i));
      chk("rnd_r",   64'(r),   64'(r_i));
      chk("rnd_dbz", 64'(dbz), 64'd0);
      chk("rnd_inv", 64'(int'(q) * b_i + int'(r)), 64'(a_i * b_i + r_i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
